// File: rtl/finger_dancer_pkg.sv
// Shared game-logic definitions for the finger-dancer judge and display stages.
package finger_dancer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int LANES   = 4;
  localparam int SCORE_W = 8;

  // Fibonacci feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7,5,4,3).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/pattern_lfsr.sv
// 8-bit Fibonacci LFSR that picks the next target lane; steps once per adv pulse.
module pattern_lfsr
  import finger_dancer_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       res,
  input  logic       adv,
  output logic [7:0] lfsr
);

  always_ff @(posedge clk) begin
    if (res) begin
      lfsr <= SEED;
    end else if (adv) begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/hit_judge.sv
// Round sequencer and hit/miss judge feeding the display's score/pattern/C inputs.
// Optional MISS_PENALTY_EN: every miss decrements score, floored at zero.
module hit_judge
  import finger_dancer_pkg::*;
#(
  parameter int         WINDOW_CYC = 50_000_000,
  parameter int         GAP_CYC    = 12_500_000,
  parameter int         ROUNDS     = 32,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic               clk,
  input  logic               res,
  input  logic               start,
  input  logic [LANES-1:0]   btn,
  output logic [LANES-1:0]   pattern,
  output logic [SCORE_W-1:0] score,
  output logic               C,
  output logic               hit,
  output logic               game_over
);

  localparam int WIN_W = $clog2(WINDOW_CYC);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYC - 1);
  localparam logic [7:0]       ROUND_LAST = 8'(ROUNDS - 1);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == {SCORE_W{1'b1}}) ? s : s + 1'b1;
  endfunction

  function automatic logic [SCORE_W-1:0] miss_score(input logic [SCORE_W-1:0] s);
`ifdef MISS_PENALTY_EN
    return (s == '0) ? s : s - 1'b1;
`else
    return s;
`endif
  endfunction

  logic [LANES-1:0]   btn_p0, btn_p1, btn_p2;
  logic [LANES-1:0]   btn_edge;
  state_t             state, state_next;
  logic [WIN_W-1:0]   win_cnt, win_next;
  logic [GAP_W-1:0]   gap_cnt, gap_next;
  logic [7:0]         round, round_next;
  logic [SCORE_W-1:0] score_next;
  logic               c_next, hit_next, adv;
  logic [7:0]         lfsr;
  logic               lfsr_unused;

  pattern_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .res  (res),
    .adv  (adv),
    .lfsr (lfsr)
  );

  // Only the low two bits select a lane; the rest is LFSR state.
  assign lfsr_unused = ^lfsr[7:2];

  // Stage p0/p1: metastability synchroniser; p2 holds the previous level for rise detection.
  assign btn_edge  = btn_p1 & ~btn_p2;
  assign pattern   = (state == SHOW) ? (LANES'(1) << lfsr[1:0]) : '0;
  assign game_over = (state == DONE);

  always_comb begin
    state_next = state;
    win_next   = win_cnt;
    gap_next   = gap_cnt;
    round_next = round;
    score_next = score;
    c_next     = 1'b0;
    hit_next   = 1'b0;
    adv        = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = SHOW;
          score_next = '0;
          round_next = '0;
          win_next   = '0;
          adv        = 1'b1;
        end
      end
      SHOW: begin
        win_next = win_cnt + 1'b1;
        // A press landing on the final window cycle is judged as a press, not a timeout.
        if (btn_edge != '0) begin
          c_next     = 1'b1;
          state_next = GAP;
          gap_next   = '0;
          if (btn_edge == pattern) begin
            hit_next   = 1'b1;
            score_next = sat_inc(score);
          end else begin
            score_next = miss_score(score);
          end
        end else if (win_cnt == WIN_LAST) begin
          c_next     = 1'b1;
          state_next = GAP;
          gap_next   = '0;
          score_next = miss_score(score);
        end
      end
      GAP: begin
        gap_next = gap_cnt + 1'b1;
        if (gap_cnt == GAP_LAST) begin
          round_next = round + 1'b1;
          if (round == ROUND_LAST) begin
            state_next = DONE;
          end else begin
            state_next = SHOW;
            win_next   = '0;
            adv        = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      btn_p0  <= '0;
      btn_p1  <= '0;
      btn_p2  <= '0;
      state   <= IDLE;
      win_cnt <= '0;
      gap_cnt <= '0;
      round   <= '0;
      score   <= '0;
      C       <= 1'b0;
      hit     <= 1'b0;
    end else begin
      btn_p0  <= btn;
      btn_p1  <= btn_p0;
      btn_p2  <= btn_p1;
      state   <= state_next;
      win_cnt <= win_next;
      gap_cnt <= gap_next;
      round   <= round_next;
      score   <= score_next;
      C       <= c_next;
      hit     <= hit_next;
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: stimulus queues expected judgements, a monitor checks each C pulse.
module tb_hit_judge;

  localparam int WIN = 8;
  localparam int GAP = 4;
  localparam int RND = 3;

  logic       clk = 1'b0;
  logic       res;
  logic       start;
  logic [3:0] btn;
  logic [3:0] pattern;
  logic [7:0] score;
  logic       C;
  logic       hit;
  logic       game_over;

  always #5 clk = ~clk;

  hit_judge #(
    .WINDOW_CYC (WIN),
    .GAP_CYC    (GAP),
    .ROUNDS     (RND),
    .SEED       (8'hA5)
  ) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .btn       (btn),
    .pattern   (pattern),
    .score     (score),
    .C         (C),
    .hit       (hit),
    .game_over (game_over)
  );

  typedef struct {
    string name;
    int    hit;
    int    score;
    int    len;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int run   = 0;
  int exp_score = 0;
  int show_idx  = 0;
  // Hand-stepped LFSR from seed A5: 4A,95,2A,54,A9,53,A7,4E,9D -> lanes 2,1,2,0,1,3,3,2,1.
  int pat_tbl[9] = '{4, 2, 4, 1, 2, 8, 8, 4, 2};

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every C pulse must match the oldest queued judgement.
  always @(negedge clk) begin : mon
    exp_t e;
    if (C) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_C: got C=1 hit=%0d score=%0d expected no judgement", hit, score);
      end else begin
        e = sb.pop_front();
        check({e.name, "_hit"}, int'(hit), e.hit);
        check({e.name, "_score"}, int'(score), e.score);
        check({e.name, "_pat_off"}, int'(pattern), 0);
        if (e.len != 0) check({e.name, "_show_len"}, run, e.len);
      end
      run = 0;
    end else if (pattern != 4'd0) begin
      run = run + 1;
    end else begin
      run = 0;
    end
  end

  task automatic wait_show(input string name, input int exp_zeros);
    int zeros;
    zeros = 0;
    @(negedge clk);
    while (pattern == 4'd0 && zeros < 100) begin
      zeros++;
      @(negedge clk);
    end
    if (pattern == 4'd0) begin
      total++;
      bad++;
      $display("FAIL %s_show_timeout: got no pattern after %0d cycles expected one", name, zeros);
    end else begin
      check({name, "_pattern"}, int'(pattern), pat_tbl[show_idx]);
      check({name, "_gap"}, zeros, exp_zeros);
    end
    if (show_idx < 8) show_idx++;
  endtask

  // kind: 0 hit, 1 wrong lane, 2 target plus neighbour, 3 no new press.
  task automatic play(input string name, input int kind, input int press_wait, input int exp_len);
    exp_t e;
    logic [3:0] p;
    int n;
    p = pattern;
    e.name = name;
    e.len  = exp_len;
    if (kind == 0) begin
      e.hit = 1;
      if (exp_score < 255) exp_score++;
    end else begin
      e.hit = 0;
`ifdef MISS_PENALTY_EN
      if (exp_score > 0) exp_score--;
`endif
    end
    e.score = exp_score;
    sb.push_back(e);
    if (kind != 3) begin
      repeat (press_wait) @(negedge clk);
      case (kind)
        0:       btn = p;
        1:       btn = {p[2:0], p[3]};
        default: btn = p | {p[2:0], p[3]};
      endcase
    end
    n = 0;
    while (pattern != 4'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (pattern != 4'd0) begin
      total++;
      bad++;
      $display("FAIL %s_judge_timeout: got pattern=%0d after %0d cycles expected 0", name, pattern, n);
    end
    btn = 4'd0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!game_over && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_game_over"}, int'(game_over), 1);
    check({name, "_done_pattern"}, int'(pattern), 0);
    check({name, "_done_score"}, int'(score), exp_score);
  endtask

  task automatic begin_game(input string name);
    start = 1'b1;
    wait_show(name, 0);
    start = 1'b0;
    exp_score = 0;
    check({name, "_score_cleared"}, int'(score), 0);
    check({name, "_game_over_low"}, int'(game_over), 0);
  endtask

  initial begin
    res   = 1'b1;
    start = 1'b1;
    btn   = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_pattern", int'(pattern), 0);
    check("rst_score", int'(score), 0);
    check("rst_C", int'(C), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_game_over", int'(game_over), 0);
    res   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_rst", int'(pattern), 0);

    // Game 1: hit, wrong lane, two lanes including target.
    begin_game("g1r1");
    play("g1r1_hit", 0, 1, 4);
    wait_show("g1r2", 3);
    play("g1r2_wrong", 1, 1, 4);
    wait_show("g1r3", 3);
    play("g1r3_multi", 2, 1, 4);
    wait_done("g1");
    btn = 4'b0001;
    repeat (3) @(negedge clk);
    btn = 4'b0110;
    repeat (3) @(negedge clk);
    btn = 4'd0;
    repeat (4) @(negedge clk);
    check("g1_done_hold", int'(game_over), 1);
    check("g1_done_score_hold", int'(score), exp_score);

    // Game 2: timeout, hit, button held across the gap.
    begin_game("g2r1");
    play("g2r1_timeout", 3, 0, WIN);
    wait_show("g2r2", 3);
    play("g2r2_hit", 0, 1, 4);
    btn = 4'b1000;
    wait_show("g2r3", 3);
    play("g2r3_held", 3, 0, WIN);
    wait_done("g2");

    // Game 3: press on last window cycle, saturation, reset mid-window.
    begin_game("g3r1");
    play("g3r1_late_hit", 0, 5, WIN);
    wait_show("g3r2", 3);
    force dut.score = 8'hFF;
    @(negedge clk);
    release dut.score;
    exp_score = 255;
    play("g3r2_sat", 0, 0, 4);
    wait_show("g3r3", 3);
    @(negedge clk);
    btn = pattern;
    @(negedge clk);
    res = 1'b1;
    repeat (2) @(negedge clk);
    res = 1'b0;
    btn = 4'd0;
    check("midrst_pattern", int'(pattern), 0);
    check("midrst_score", int'(score), 0);
    check("midrst_C", int'(C), 0);
    check("midrst_game_over", int'(game_over), 0);
    repeat (6) @(negedge clk);
    check("midrst_idle", int'(pattern), 0);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 expected earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
